// File: rtl/quiz_round_ctrl.sv
// Quiz-buzzer round controller: arm on Start, arbitrate four keys, flag fouls/timeouts, hold until Clear.
// Latency: every output reflects the inputs sampled at the previous CP edge (1 edge).
// Backpressure: none; inputs are sampled every cycle and results are held until Clear.
//
// Ports:
//   CP, Rst            clock and synchronous active-high reset
//   Start, Clear       host keys (Start acts on its rising edge, Clear is a level)
//   Key[3:0]           contestant keys, rising edge acts, Key[0] wins ties
//   t_up               countdown expired flag, only honoured while ARMED
//   cd_en              countdown enable (high only while ARMED)
//   state              0 IDLE, 1 ARMED, 2 LOCKED, 3 FOUL, 4 TIMEOUT
//   winner/winner_valid/lamp  locked or fouling contestant
//   buzzer             BUZZ_CYCLES-long pulse on entry to a result state
//   round_cnt          rounds armed, modulo 16
module quiz_round_ctrl #(
    parameter int unsigned BUZZ_CYCLES = 4
) (
    input  logic       CP,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Clear,
    input  logic [3:0] Key,
    input  logic       t_up,
    output logic       cd_en,
    output logic [2:0] state,
    output logic [1:0] winner,
    output logic       winner_valid,
    output logic [3:0] lamp,
    output logic       buzzer,
    output logic [3:0] round_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_LOCKED  = 3'd2,
        S_FOUL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    localparam logic [3:0] BUZZ_LOAD = 4'(BUZZ_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] round_cnt_q, round_cnt_d;
    logic [3:0] buzz_cnt_q, buzz_cnt_d;
    logic [3:0] key_q;
    logic       start_q;

    logic [3:0] key_rise;
    logic       start_rise;
    logic       any_rise;
    logic [1:0] rise_idx;

    assign key_rise   = Key & ~key_q;
    assign start_rise = Start & ~start_q;
    assign any_rise   = |key_rise;

    // Lowest set bit wins: scan from the top so the lowest index is written last.
    always_comb begin
        rise_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_rise[i]) begin
                rise_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        round_cnt_d = round_cnt_q;
        buzz_cnt_d  = (buzz_cnt_q != 4'd0) ? (buzz_cnt_q - 4'd1) : 4'd0;

        if (Clear) begin
            state_d    = S_IDLE;
            winner_d   = 2'd0;
            buzz_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A key pressed before the round is armed is a foul, even
                    // if Start rises in the same cycle.
                    if (any_rise) begin
                        state_d    = S_FOUL;
                        winner_d   = rise_idx;
                        buzz_cnt_d = BUZZ_LOAD;
                    end else if (start_rise) begin
                        state_d     = S_ARMED;
                        round_cnt_d = round_cnt_q + 4'd1;
                    end
                end
                S_ARMED: begin
                    // A key arriving together with expiry still counts as an answer.
                    if (any_rise) begin
                        state_d    = S_LOCKED;
                        winner_d   = rise_idx;
                        buzz_cnt_d = BUZZ_LOAD;
                    end else if (t_up) begin
                        state_d    = S_TIMEOUT;
                        buzz_cnt_d = BUZZ_LOAD;
                    end
                end
                S_LOCKED, S_FOUL, S_TIMEOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d    = S_IDLE;
                    winner_d   = 2'd0;
                    buzz_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            winner_q    <= 2'd0;
            round_cnt_q <= 4'd0;
            buzz_cnt_q  <= 4'd0;
            // Treat inputs as already high so a key or Start held through
            // reset has to be released and pressed again before it acts.
            key_q       <= 4'b1111;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            round_cnt_q <= round_cnt_d;
            buzz_cnt_q  <= buzz_cnt_d;
            key_q       <= Key;
            start_q     <= Start;
        end
    end

    // Outputs are pure decodes of registered state, so they move only on CP.
    assign state        = state_q;
    assign cd_en        = (state_q == S_ARMED);
    assign winner       = winner_q;
    assign winner_valid = (state_q == S_LOCKED) || (state_q == S_FOUL);
    assign lamp         = winner_valid ? (4'b0001 << winner_q) : 4'b0000;
    assign buzzer       = (buzz_cnt_q != 4'd0);
    assign round_cnt    = round_cnt_q;

endmodule
